// File: rtl/adc_scan_pkg.sv
// Shared types and helpers for the ADC scan sequencer: state encoding, channel
// width helper and the next-enabled-channel search.
package adc_scan_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETTLE  = 3'd1;
    localparam state_t ST_DISCARD = 3'd2;
    localparam state_t ST_ACCUM   = 3'd3;
    localparam state_t ST_PUBLISH = 3'd4;

    localparam int MAX_CH = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } bit_sel_t;

    function automatic int ch_width(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

    // Lowest set bit of mask at or above index 'from'.
    function automatic bit_sel_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                              input logic [4:0] from);
        bit_sel_t r;
        r.found = 1'b0;
        r.idx   = 4'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (!r.found && mask[i] && (5'(i) >= from)) begin
                r.found = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_scan_sequencer_bank.sv
// Per-channel result bank: one write port, registered read port with
// read-before-write behaviour and zero for out-of-range addresses.
module adc_result_bank #(
    parameter int NUM_CH     = 4,
    parameter int RAMP_WIDTH = 8,
    parameter int CH_W       = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_we,
    input  logic [CH_W-1:0]       i_wr_ch,
    input  logic [RAMP_WIDTH-1:0] i_wr_data,
    input  logic [CH_W-1:0]       i_rd_ch,
    output logic [RAMP_WIDTH-1:0] o_rd_data
);

    logic [RAMP_WIDTH-1:0] r_bank [NUM_CH];
    logic [RAMP_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_bank[i] <= '0;
            end
            r_rd_data <= '0;
        end else begin
            if (i_we) begin
                r_bank[i_wr_ch] <= i_wr_data;
            end
            r_rd_data <= (int'(i_rd_ch) < NUM_CH) ? r_bank[i_rd_ch] : '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/adc_scan_sequencer.sv
// Multiplexes one SAR ADC over NUM_CH inputs: settle, discard, average, publish.
// Optional per-conversion watchdog enabled by defining ADC_SCAN_TIMEOUT_EN.
module adc_scan_sequencer
    import adc_scan_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int RAMP_WIDTH        = 8,
    parameter int AVG_LOG2          = 2,
    parameter int MUX_SETTLE_CYCLES = 1000,
    parameter int TIMEOUT_CYCLES    = 2000000,
    localparam int CH_W             = ch_width(NUM_CH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_scan_start,
    input  logic                  i_scan_continuous,
    input  logic [NUM_CH-1:0]     i_ch_mask,
    input  logic                  i_adc_ready,
    input  logic [RAMP_WIDTH-1:0] i_adc_code,
    output logic                  o_adc_hold,
    output logic [CH_W-1:0]       o_mux_sel,
    output logic                  o_busy,
    output logic                  o_result_valid,
    output logic [CH_W-1:0]       o_result_ch,
    output logic [RAMP_WIDTH-1:0] o_result_code,
    output logic                  o_scan_done,
    input  logic [CH_W-1:0]       i_rd_ch,
    output logic [RAMP_WIDTH-1:0] o_rd_data,
    output logic                  o_timeout_err
);

    localparam int NSAMP   = 1 << AVG_LOG2;
    localparam int ACC_W   = RAMP_WIDTH + AVG_LOG2;
    localparam int CNT_MAX = (MUX_SETTLE_CYCLES > NSAMP) ? MUX_SETTLE_CYCLES : NSAMP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    if (NUM_CH < 2 || NUM_CH > MAX_CH || AVG_LOG2 < 0 || AVG_LOG2 > 4 ||
        MUX_SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("adc_scan_sequencer: parameter out of range");
    end

    state_t                r_state;
    logic [NUM_CH-1:0]     r_mask;
    logic                  r_cont;
    logic [CH_W-1:0]       r_ptr;
    logic [CNT_W-1:0]      r_cnt;
    logic [ACC_W-1:0]      r_acc;
    logic                  r_result_valid;
    logic [CH_W-1:0]       r_result_ch;
    logic [RAMP_WIDTH-1:0] r_result_code;
    logic                  r_scan_done;

    logic [ACC_W-1:0]      w_sum;
    bit_sel_t              w_next;
    bit_sel_t              w_first;
    logic                  w_last_sample;
    logic                  w_timeout;

    assign w_sum         = r_acc + ACC_W'(i_adc_code);
    assign w_next        = next_set_bit(16'(r_mask), 5'(r_ptr) + 5'd1);
    assign w_first       = next_set_bit(16'(i_ch_mask), 5'd0);
    assign w_last_sample = (r_state == ST_ACCUM) && i_adc_ready &&
                           (r_cnt == CNT_W'(NSAMP - 1));

`ifdef ADC_SCAN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wdog;
    logic            r_timeout_err;
    logic            w_waiting;

    assign w_waiting = (r_state == ST_DISCARD) || (r_state == ST_ACCUM);
    assign w_timeout = w_waiting && !i_adc_ready && (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wdog        <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (!w_waiting || i_adc_ready) begin
                r_wdog <= '0;
            end else begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign o_timeout_err = r_timeout_err;
`else
    assign w_timeout     = 1'b0;
    assign o_timeout_err = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= ST_IDLE;
            r_mask         <= '0;
            r_cont         <= 1'b0;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_acc          <= '0;
            r_result_valid <= 1'b0;
            r_result_ch    <= '0;
            r_result_code  <= '0;
            r_scan_done    <= 1'b0;
        end else begin
            r_result_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_scan_start && w_first.found) begin
                        r_mask  <= i_ch_mask;
                        r_cont  <= i_scan_continuous;
                        r_ptr   <= CH_W'(w_first.idx);
                        r_cnt   <= '0;
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == CNT_W'(MUX_SETTLE_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= ST_DISCARD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DISCARD: begin
                    if (i_adc_ready) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (i_adc_ready) begin
                        r_acc <= w_sum;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_PUBLISH: begin
                    r_cnt <= '0;
                    if (w_next.found) begin
                        r_ptr   <= CH_W'(w_next.idx);
                        r_state <= ST_SETTLE;
                    end else if (r_cont && i_scan_continuous && w_first.found) begin
                        // A dropped continuous bit ends the scan at this pass boundary.
                        r_mask  <= i_ch_mask;
                        r_ptr   <= CH_W'(w_first.idx);
                        r_state <= ST_SETTLE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            if (w_last_sample || w_timeout) begin
                r_state        <= ST_PUBLISH;
                r_result_valid <= 1'b1;
                r_result_ch    <= r_ptr;
                r_result_code  <= w_timeout ? '0 : RAMP_WIDTH'(w_sum >> AVG_LOG2);
                r_scan_done    <= !w_next.found;
            end
        end
    end

    adc_result_bank #(
        .NUM_CH     (NUM_CH),
        .RAMP_WIDTH (RAMP_WIDTH),
        .CH_W       (CH_W)
    ) u_bank (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_we      (r_state == ST_PUBLISH),
        .i_wr_ch   (r_result_ch),
        .i_wr_data (r_result_code),
        .i_rd_ch   (i_rd_ch),
        .o_rd_data (o_rd_data)
    );

    assign o_adc_hold     = (r_state == ST_IDLE) || (r_state == ST_SETTLE);
    assign o_busy         = (r_state != ST_IDLE);
    assign o_mux_sel      = r_ptr;
    assign o_result_valid = r_result_valid;
    assign o_result_ch    = r_result_ch;
    assign o_result_code  = r_result_code;
    assign o_scan_done    = r_scan_done;

endmodule
